ultrasonic_scheduler: RTL and testbench
=======================================

Name: ultrasonic_scheduler

Overview:
Round-robin trigger/sequencing controller for a bank of HC-SR04-style ultrasonic sensors sharing one echo-width measurement path. For each sensor in turn it issues the trigger pulse, selects that sensor's echo, measures echo high-time in clock cycles, and reports the raw count with sensor ID. A holdoff gap between sensors prevents crosstalk. Output feeds the existing averaging/divide-to-distance datapath.

Parameters:
NUM_SENSORS, 4, number of sensors scheduled (>=2)
TRIG_CYCLES, 1000, trigger high time in clk cycles (10 us at 100 MHz)
RISE_TIMEOUT, 100000, max cycles from trigger end to echo rising edge
MAX_ECHO, 2500000, max echo high cycles before measurement aborts (fits 24 bits)
HOLDOFF_CYCLES, 6000000, idle gap after each slot before next trigger

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
enable  in  1  run scheduler; low = stop after current slot
echo  in  NUM_SENSORS  asynchronous echo lines, one per sensor
trig  out  NUM_SENSORS  trigger outputs, one-hot or zero
sensor_id  out  $clog2(NUM_SENSORS)  ID of sensor currently/last scheduled
echo_count  out  24  measured echo high-time in cycles
count_valid  out  1  one-cycle pulse: echo_count/result_id/timeout valid
result_id  out  $clog2(NUM_SENSORS)  sensor that produced the result
timeout  out  1  qualifies count_valid: measurement aborted
busy  out  1  high in any state except IDLE

Behaviour:
- Clock is clk; reset is synchronous and active-high. On reset all outputs 0, state IDLE, sensor_id 0, sync flops 0.
- Each echo bit passes through a 2-flop synchronizer; edge detect on the selected sync echo vs. its previous sample (prev cleared on entering TRIG).
- States: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE: enable=1 -> TRIG for sensor_id.
- TRIG: trig[sensor_id]=1 for exactly TRIG_CYCLES cycles, then WAIT_RISE; all other trig bits 0 always.
- WAIT_RISE: waits for rising edge (sync echo 0->1). Echo already high on entry does not count; a rising edge is required. Rising edge -> MEASURE, counter=1. RISE_TIMEOUT cycles without rise -> count_valid=1, timeout=1, echo_count=0, then HOLDOFF.
- MEASURE: counter +1 each cycle sync echo=1. First cycle sync echo=0 -> count_valid=1, timeout=0, echo_count=counter (pulse of H sync-high cycles reports H), -> HOLDOFF. Counter reaching MAX_ECHO while echo still high -> count_valid=1, timeout=1, echo_count=MAX_ECHO, -> HOLDOFF.
- HOLDOFF: HOLDOFF_CYCLES cycles, then sensor_id increments modulo NUM_SENSORS (NUM_SENSORS-1 wraps to 0); enable=1 -> TRIG, else IDLE.
- Latency: count_valid asserted the cycle after the falling edge is seen on the synchronized echo (3 clk after raw echo falls).
- result_id/echo_count/timeout hold until next count_valid; count_valid exactly one cycle per slot.
- enable deasserted mid-slot: slot completes incl. HOLDOFF, then IDLE; no trigger issued while enable=0 in IDLE.
- Echoes on non-selected sensors ignored.
- Reset mid-operation: trig drops next edge, no count_valid emitted.

Optional Feature:
SENSOR_MASK_EN: adds input sensor_mask [NUM_SENSORS-1:0]. At HOLDOFF exit (and IDLE->TRIG) the next sensor_id is the next set mask bit in round-robin order after the current one (current included only if it is the sole set bit); all-zero mask -> stay in IDLE, busy=0. Without macro: no port, all sensors scheduled in order.

Test Plan:
- Params TRIG=4, RISE_TIMEOUT=20, MAX_ECHO=50, HOLDOFF=8; enable=1, sensor 0 echo rises 5 cycles after trig falls, high 17 cycles -> trig[0] high exactly 4 cycles, count_valid once, echo_count=17, result_id=0, timeout=0.
- Sensor 1 never echoes -> count_valid with timeout=1, echo_count=0, result_id=1, 20 cycles after trig[1] falls (+1).
- Sensor 2 echo stuck high from before trigger -> no rise seen -> rise timeout (timeout=1, echo_count=0); then sensor 2 echo held high 60 cycles after proper rise -> echo_count=50, timeout=1.
- Four slots with enable=1 -> sensor_id sequence 0,1,2,3,0; trig never multi-hot; toggling non-selected echoes changes nothing.
- enable dropped during MEASURE -> result reported, HOLDOFF completes, IDLE, busy=0, no further trig; reset asserted during TRIG -> trig=0 and all outputs 0 next cycle.
- SENSOR_MASK_EN, mask=4'b1010 -> order 1,3,1,3; mask=0 -> stays IDLE.

Source files
------------

// File: rtl/ultrasonic_scheduler_if.sv
// Scheduler <-> system signal bundle; sensor_mask exists only when SENSOR_MASK_EN is defined.
interface ultrasonic_scheduler_if #(
    parameter int NUM_SENSORS = 4
);
    localparam int ID_W = $clog2(NUM_SENSORS);

    logic                   enable;
    logic [NUM_SENSORS-1:0] echo;
    logic [NUM_SENSORS-1:0] trig;
    logic [ID_W-1:0]        sensor_id;
    logic [23:0]            echo_count;
    logic                   count_valid;
    logic [ID_W-1:0]        result_id;
    logic                   timeout;
    logic                   busy;

`ifdef SENSOR_MASK_EN
    logic [NUM_SENSORS-1:0] sensor_mask;

    modport master (
        input  enable, echo, sensor_mask,
        output trig, sensor_id, echo_count, count_valid, result_id, timeout, busy
    );
    modport slave (
        output enable, echo, sensor_mask,
        input  trig, sensor_id, echo_count, count_valid, result_id, timeout, busy
    );
`else
    modport master (
        input  enable, echo,
        output trig, sensor_id, echo_count, count_valid, result_id, timeout, busy
    );
    modport slave (
        output enable, echo,
        input  trig, sensor_id, echo_count, count_valid, result_id, timeout, busy
    );
`endif
endinterface

// File: rtl/ultrasonic_scheduler.sv
// Round-robin trigger/echo-width scheduler for a bank of ultrasonic sensors sharing one counter.
// Optional macro SENSOR_MASK_EN adds sensor_mask to skip sensors in the rotation.
module ultrasonic_scheduler #(
    parameter int NUM_SENSORS    = 4,
    parameter int TRIG_CYCLES    = 1000,
    parameter int RISE_TIMEOUT   = 100000,
    parameter int MAX_ECHO       = 2500000,
    parameter int HOLDOFF_CYCLES = 6000000
) (
    input logic clk,
    input logic reset,
    ultrasonic_scheduler_if.master bus
);
    localparam int ID_W  = $clog2(NUM_SENSORS);
    localparam int CNT_W = 24;
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] ECHO_MAX  = CNT_W'(MAX_ECHO);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

    state_t                 state;
    logic [NUM_SENSORS-1:0] echo_sync_p0;
    logic [NUM_SENSORS-1:0] echo_sync_p1;
    logic                   echo_prev_p2;
    logic [CNT_W-1:0]       cnt;
    logic [ID_W-1:0]        sensor_id;
    logic [ID_W-1:0]        result_id;
    logic [NUM_SENSORS-1:0] trig;
    logic [23:0]            echo_count;
    logic                   count_valid;
    logic                   timeout;
    logic                   busy;
    logic [ID_W-1:0]        idle_id;
    logic [ID_W-1:0]        hold_id;
    logic                   can_start;
    logic                   echo_sel;
    logic                   echo_rise;

    function automatic logic [NUM_SENSORS-1:0] onehot(input logic [ID_W-1:0] id);
        return NUM_SENSORS'(1) << id;
    endfunction

`ifdef SENSOR_MASK_EN
    // Nearest set bit after cur wins; cur itself is the fallback (or first choice when incl_cur).
    function automatic logic [ID_W-1:0] mask_pick(input logic [ID_W-1:0]        cur,
                                                  input logic [NUM_SENSORS-1:0] mask,
                                                  input logic                   incl_cur);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] cand;
        pick = cur;
        for (int k = NUM_SENSORS; k >= 1; k--) begin
            cand = ID_W'((int'(cur) + k) % NUM_SENSORS);
            if (mask[cand]) pick = cand;
        end
        if (incl_cur && mask[cur]) pick = cur;
        return pick;
    endfunction

    assign can_start = |bus.sensor_mask;
    assign idle_id   = mask_pick(sensor_id, bus.sensor_mask, 1'b1);
    assign hold_id   = mask_pick(sensor_id, bus.sensor_mask, 1'b0);
`else
    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] cur);
        return (cur == ID_W'(NUM_SENSORS - 1)) ? '0 : cur + 1'b1;
    endfunction

    assign can_start = 1'b1;
    assign idle_id   = sensor_id;
    assign hold_id   = rr_next(sensor_id);
`endif

    assign echo_sel  = echo_sync_p1[sensor_id];
    assign echo_rise = echo_sel & ~echo_prev_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            echo_sync_p0 <= '0;
            echo_sync_p1 <= '0;
            echo_prev_p2 <= 1'b0;
            cnt          <= '0;
            sensor_id    <= '0;
            result_id    <= '0;
            trig         <= '0;
            echo_count   <= '0;
            count_valid  <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // Stage p0/p1: two-flop synchronizer on every raw echo line
            echo_sync_p0 <= bus.echo;
            echo_sync_p1 <= echo_sync_p0;
            // Stage p2: previous sample of the selected line for edge detection
            echo_prev_p2 <= echo_sel;
            count_valid  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.enable && can_start) begin
                        sensor_id    <= idle_id;
                        trig         <= onehot(idle_id);
                        echo_prev_p2 <= 1'b0;
                        cnt          <= '0;
                        busy         <= 1'b1;
                        state        <= TRIG;
                    end
                end
                TRIG: begin
                    if (cnt == TRIG_LAST) begin
                        trig  <= '0;
                        cnt   <= '0;
                        state <= WAIT_RISE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_RISE: begin
                    if (echo_rise) begin
                        cnt   <= CNT_W'(1);
                        state <= MEASURE;
                    end else if (cnt == RISE_LAST) begin
                        echo_count  <= '0;
                        timeout     <= 1'b1;
                        result_id   <= sensor_id;
                        count_valid <= 1'b1;
                        cnt         <= '0;
                        state       <= HOLDOFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (!echo_sel) begin
                        echo_count  <= cnt;
                        timeout     <= 1'b0;
                        result_id   <= sensor_id;
                        count_valid <= 1'b1;
                        cnt         <= '0;
                        state       <= HOLDOFF;
                    end else if (cnt == ECHO_MAX) begin
                        echo_count  <= ECHO_MAX;
                        timeout     <= 1'b1;
                        result_id   <= sensor_id;
                        count_valid <= 1'b1;
                        cnt         <= '0;
                        state       <= HOLDOFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
                        sensor_id <= hold_id;
                        cnt       <= '0;
                        if (bus.enable && can_start) begin
                            trig         <= onehot(hold_id);
                            echo_prev_p2 <= 1'b0;
                            state        <= TRIG;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.trig        = trig;
    assign bus.sensor_id   = sensor_id;
    assign bus.echo_count  = echo_count;
    assign bus.count_valid = count_valid;
    assign bus.result_id   = result_id;
    assign bus.timeout     = timeout;
    assign bus.busy        = busy;
endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed + randomized slot-level bench for ultrasonic_scheduler against a per-slot result model.
module tb_ultrasonic_scheduler;
    localparam int NS   = 4;
    localparam int TRIG = 4;
    localparam int RISE = 20;
    localparam int MAXE = 50;
    localparam int HOLD = 8;
    localparam int ID_W = $clog2(NS);
    localparam int K_NORMAL = 0;
    localparam int K_NONE   = 1;
    localparam int K_STUCK  = 2;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    int   vpulses     = 0;
    bit   mon_en      = 1'b0;
    logic [ID_W-1:0] exp_id;

    ultrasonic_scheduler_if #(.NUM_SENSORS(NS)) bus ();

    ultrasonic_scheduler #(
        .NUM_SENSORS(NS), .TRIG_CYCLES(TRIG), .RISE_TIMEOUT(RISE),
        .MAX_ECHO(MAXE), .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("trig_onehot0", {31'd0, $onehot0(bus.trig)}, 32'd1);
            if (bus.count_valid === 1'b1) vpulses++;
        end
    end

    // Random levels on every line except the selected sensor, which gets v.
    function automatic logic [NS-1:0] mix(input logic v);
        logic [NS-1:0] m;
        m = NS'($urandom);
        m[exp_id] = v;
        return m;
    endfunction

    // {timeout, echo_count} a slot must report, from the echo shape alone.
    function automatic logic [24:0] expect_result(input int kind, input int h);
        if (kind != K_NORMAL) return {1'b1, 24'd0};
        if (h > MAXE) return {1'b1, 24'(MAXE)};
        return {1'b0, 24'(h)};
    endfunction

    task automatic run_slot(input int kind, input int d, input int h, input bit drop_en);
        int              cyc;
        int              thi;
        int              lat;
        int              p0;
        bit              seen;
        logic            sel_v;
        logic [23:0]     cnt_seen;
        logic            tmo_seen;
        logic [ID_W-1:0] rid_seen;
        logic [24:0]     exp_res;
        exp_res  = expect_result(kind, h);
        sel_v    = (kind == K_STUCK);
        lat      = 0;
        seen     = 1'b0;
        cnt_seen = 'x;
        tmo_seen = 1'bx;
        rid_seen = 'x;
        bus.echo = '0;
        bus.echo[exp_id] = sel_v;
        cyc = 0;
        while (bus.trig === '0 && cyc < 100) begin
            @(negedge clk);
            bus.echo = mix(sel_v);
            cyc++;
        end
        chk("trig_select", 32'(bus.trig), 32'(NS'(1) << exp_id));
        chk("sensor_id", 32'(bus.sensor_id), 32'(exp_id));
        chk("busy_in_slot", 32'(bus.busy), 32'd1);
        p0  = vpulses;
        thi = 0;
        while (bus.trig !== '0 && thi < 100) begin
            thi++;
            @(negedge clk);
            bus.echo = mix(sel_v);
        end
        chk("trig_width", thi, TRIG);
        cyc = 0;
        while (!seen && cyc < 200) begin
            if (kind == K_NORMAL) sel_v = (cyc >= d) && (cyc < d + h);
            bus.echo = mix(sel_v);
            if (drop_en && cyc == d + 4) bus.enable = 1'b0;
            @(negedge clk);
            cyc++;
            if (bus.count_valid === 1'b1) begin
                seen     = 1'b1;
                lat      = cyc;
                cnt_seen = bus.echo_count;
                tmo_seen = bus.timeout;
                rid_seen = bus.result_id;
            end
        end
        chk("valid_seen", 32'(seen), 32'd1);
        chk("echo_count", 32'(cnt_seen), 32'(exp_res[23:0]));
        chk("timeout", 32'(tmo_seen), 32'(exp_res[24]));
        chk("result_id", 32'(rid_seen), 32'(exp_id));
        if (kind != K_NORMAL)
            chk("rise_timeout_latency", 32'((lat == RISE) || (lat == RISE + 1)), 32'd1);
        else if (!exp_res[24])
            chk("fall_latency", lat, d + h + 3);
        bus.echo = '0;
        @(negedge clk);
        chk("valid_one_cycle", 32'(bus.count_valid), 32'd0);
        #1;
        chk("valid_once_per_slot", vpulses - p0, 1);
        exp_id = ID_W'((int'(exp_id) + 1) % NS);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ntrig;
        int cyc;
        int kind;
        int d;
        int h;
        int p0;
        reset      = 1'b1;
        bus.enable = 1'b0;
        bus.echo   = '0;
`ifdef SENSOR_MASK_EN
        bus.sensor_mask = '1;
`endif
        exp_id = '0;
        repeat (3) @(negedge clk);
        chk("rst_trig", 32'(bus.trig), 0);
        chk("rst_sensor_id", 32'(bus.sensor_id), 0);
        chk("rst_echo_count", 32'(bus.echo_count), 0);
        chk("rst_count_valid", 32'(bus.count_valid), 0);
        chk("rst_result_id", 32'(bus.result_id), 0);
        chk("rst_timeout", 32'(bus.timeout), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        ntrig = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.echo = NS'($urandom);
            if (bus.trig !== '0) ntrig++;
        end
        chk("idle_disabled_no_trig", ntrig, 0);
        chk("idle_disabled_busy", 32'(bus.busy), 0);

        bus.enable = 1'b1;
        run_slot(K_NORMAL, 5, 17, 1'b0);
        run_slot(K_NONE, 0, 0, 1'b0);
        run_slot(K_STUCK, 0, 0, 1'b0);
        run_slot(K_NORMAL, $urandom_range(0, 12), $urandom_range(1, 45), 1'b0);
        run_slot(K_NORMAL, $urandom_range(0, 12), $urandom_range(1, 45), 1'b0);
        run_slot(K_NORMAL, $urandom_range(0, 12), $urandom_range(1, 45), 1'b0);
        run_slot(K_NORMAL, 3, 60, 1'b0);

        for (int i = 0; i < 10; i++) begin
            kind = $urandom_range(0, 9);
            kind = (kind == 0) ? K_NONE : (kind == 1) ? K_STUCK : K_NORMAL;
            d    = $urandom_range(0, 12);
            h    = $urandom_range(1, 70);
            if (h == MAXE) h = MAXE + 1;
            run_slot(kind, d, h, 1'b0);
        end

        run_slot(K_NORMAL, 4, 20, 1'b1);
        ntrig = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.trig !== '0) ntrig++;
        end
        chk("stop_busy", 32'(bus.busy), 0);
        chk("stop_no_trig", ntrig, 0);
        chk("stop_next_id", 32'(bus.sensor_id), 32'(exp_id));

        bus.enable = 1'b1;
        run_slot(K_NORMAL, 6, 33, 1'b0);

        cyc = 0;
        while (bus.trig === '0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("pre_reset_trig", 32'(bus.trig), 32'(NS'(1) << exp_id));
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_trig", 32'(bus.trig), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_sensor_id", 32'(bus.sensor_id), 0);
        chk("midrst_count_valid", 32'(bus.count_valid), 0);
        chk("midrst_echo_count", 32'(bus.echo_count), 0);
        chk("midrst_result_id", 32'(bus.result_id), 0);
        chk("midrst_timeout", 32'(bus.timeout), 0);
        #1;
        p0 = vpulses;
        repeat (3) @(negedge clk);
        #1;
        chk("midrst_no_valid", vpulses - p0, 0);
        reset  = 1'b0;
        exp_id = '0;
        run_slot(K_NORMAL, 2, 9, 1'b0);

`ifdef SENSOR_MASK_EN
        bus.sensor_mask = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            exp_id = (i % 2 == 0) ? ID_W'(1) : ID_W'(3);
            run_slot(K_NORMAL, 3, 5 + i, 1'b0);
        end
        bus.sensor_mask = '0;
        ntrig = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.trig !== '0) ntrig++;
        end
        chk("mask_zero_busy", 32'(bus.busy), 0);
        chk("mask_zero_no_trig", ntrig, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
